// File: rtl/fifo_address_sync_packet.sv
// Single-clock FIFO address and flag controller for an external dual-port RAM
// with registered read, with optional packet commit/abort on the write side.
module fifo_address_sync_packet #(
    parameter int unsigned C_ADDRESS_WIDTH          = 4,
    parameter int unsigned C_ALMOST_EMPTY_THRESHOLD = 2,
    parameter int unsigned C_ALMOST_FULL_THRESHOLD  = 2,
    parameter int unsigned C_PACKET_MODE            = 0
) (
    input  logic                       clk,
    input  logic                       resetn,

    input  logic                       s_axis_valid,
    output logic                       s_axis_ready,
    input  logic                       s_axis_last,
    input  logic                       s_axis_abort,
    output logic [C_ADDRESS_WIDTH-1:0] s_axis_waddr,
    output logic                       s_axis_empty,
    output logic [C_ADDRESS_WIDTH:0]   s_axis_room,
    output logic                       s_axis_almost_full,

    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic [C_ADDRESS_WIDTH-1:0] m_axis_raddr_next,
    output logic [C_ADDRESS_WIDTH:0]   m_axis_level,
    output logic                       m_axis_almost_empty
);

    localparam int unsigned AW = C_ADDRESS_WIDTH;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned D  = 1 << AW;

    localparam logic [PW-1:0] DEPTH = PW'(D);
    localparam logic [PW-1:0] AE_TH = PW'(C_ALMOST_EMPTY_THRESHOLD);
    localparam logic [PW-1:0] AF_TH = PW'(C_ALMOST_FULL_THRESHOLD);
    localparam logic [PW-1:0] ONE   = PW'(1);

    logic [PW-1:0] waddr;
    logic [PW-1:0] caddr;
    logic [PW-1:0] raddr;
    logic [PW-1:0] waddr_next;
    logic [PW-1:0] caddr_next;
    logic [PW-1:0] raddr_next;

    logic          write_acc;
    logic          read_acc;

    logic [PW-1:0] used_next;
    logic [PW-1:0] room_next;
    logic [PW-1:0] level_next;
    logic          ready_next;
    logic          valid_next;
    logic          empty_next;
    logic          almost_full_next;
    logic          almost_empty_next;

    // Handshakes qualified by the registered flags; both sides share one clock.
    assign write_acc = s_axis_valid & s_axis_ready;
    assign read_acc  = m_axis_valid & m_axis_ready;

    // Pointer update; reset forces the next values to zero so the read
    // address presented to the RAM is already 0 during the reset cycle.
    always_comb begin
        waddr_next = waddr;
        caddr_next = caddr;
        raddr_next = raddr;

        if (write_acc) begin
            waddr_next = waddr + ONE;
        end
        if (read_acc) begin
            raddr_next = raddr + ONE;
        end

        if (C_PACKET_MODE != 0) begin
            if (write_acc && s_axis_last) begin
                caddr_next = waddr + ONE;
            end
            // Abort rewinds to the (possibly just updated) commit point.
            if (s_axis_abort) begin
                waddr_next = caddr_next;
            end
        end else begin
            caddr_next = waddr_next;
        end

        if (!resetn) begin
            waddr_next = '0;
            caddr_next = '0;
            raddr_next = '0;
        end
    end

    // Flags derived from the next pointers so they are exact one cycle after any event.
    always_comb begin
        used_next         = waddr_next - raddr_next;
        room_next         = DEPTH - used_next;
        level_next        = caddr_next - raddr_next;
        ready_next        = (used_next != DEPTH);
        valid_next        = (caddr_next != raddr_next);
        empty_next        = (waddr_next == raddr_next);
        almost_full_next  = (room_next <= AF_TH);
        almost_empty_next = (level_next <= AE_TH);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            waddr               <= '0;
            caddr               <= '0;
            raddr               <= '0;
            s_axis_ready        <= 1'b1;
            s_axis_empty        <= 1'b1;
            s_axis_room         <= DEPTH;
            s_axis_almost_full  <= (DEPTH <= AF_TH);
            m_axis_valid        <= 1'b0;
            m_axis_level        <= '0;
            m_axis_almost_empty <= 1'b1;
        end else begin
            waddr               <= waddr_next;
            caddr               <= caddr_next;
            raddr               <= raddr_next;
            s_axis_ready        <= ready_next;
            s_axis_empty        <= empty_next;
            s_axis_room         <= room_next;
            s_axis_almost_full  <= almost_full_next;
            m_axis_valid        <= valid_next;
            m_axis_level        <= level_next;
            m_axis_almost_empty <= almost_empty_next;
        end
    end

    assign s_axis_waddr      = waddr[AW-1:0];
    assign m_axis_raddr_next = raddr_next[AW-1:0];

endmodule

// File: tb/tb_fifo_address_sync_packet.sv
// Directed bench for fifo_address_sync_packet: one streaming and one packet-mode
// instance, with queue scoreboards of expected read addresses and fill models.
module tb_fifo_address_sync_packet;

    localparam int D = 16;

    logic clk;
    logic resetn;

    logic       a_sv, a_sl, a_sa, a_mr;
    logic       a_ready, a_empty, a_af, a_mvalid, a_ae;
    logic [3:0] a_waddr, a_raddr;
    logic [4:0] a_room, a_level;

    logic       p_sv, p_sl, p_sa, p_mr;
    logic       p_ready, p_empty, p_af, p_mvalid, p_ae;
    logic [3:0] p_waddr, p_raddr;
    logic [4:0] p_room, p_level;

    int total = 0;
    int bad   = 0;

    int aq[$];
    int pq[$];
    int pend[$];

    fifo_address_sync_packet #(
        .C_ADDRESS_WIDTH(4), .C_ALMOST_EMPTY_THRESHOLD(2),
        .C_ALMOST_FULL_THRESHOLD(2), .C_PACKET_MODE(0)
    ) u_stream (
        .clk(clk), .resetn(resetn),
        .s_axis_valid(a_sv), .s_axis_ready(a_ready), .s_axis_last(a_sl),
        .s_axis_abort(a_sa), .s_axis_waddr(a_waddr), .s_axis_empty(a_empty),
        .s_axis_room(a_room), .s_axis_almost_full(a_af),
        .m_axis_valid(a_mvalid), .m_axis_ready(a_mr), .m_axis_raddr_next(a_raddr),
        .m_axis_level(a_level), .m_axis_almost_empty(a_ae)
    );

    fifo_address_sync_packet #(
        .C_ADDRESS_WIDTH(4), .C_ALMOST_EMPTY_THRESHOLD(2),
        .C_ALMOST_FULL_THRESHOLD(2), .C_PACKET_MODE(1)
    ) u_packet (
        .clk(clk), .resetn(resetn),
        .s_axis_valid(p_sv), .s_axis_ready(p_ready), .s_axis_last(p_sl),
        .s_axis_abort(p_sa), .s_axis_waddr(p_waddr), .s_axis_empty(p_empty),
        .s_axis_room(p_room), .s_axis_almost_full(p_af),
        .m_axis_valid(p_mvalid), .m_axis_ready(p_mr), .m_axis_raddr_next(p_raddr),
        .m_axis_level(p_level), .m_axis_almost_empty(p_ae)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Flags and counts of both instances against the bench's occupancy models.
    task automatic check_model();
        int pu;
        pu = pq.size() + pend.size();
        chk("a_level", 32'(a_level), 32'(aq.size()));
        chk("a_room", 32'(a_room), 32'(D - aq.size()));
        chk("a_ready", 32'(a_ready), 32'(aq.size() != D));
        chk("a_valid", 32'(a_mvalid), 32'(aq.size() != 0));
        chk("a_empty", 32'(a_empty), 32'(aq.size() == 0));
        chk("a_almost_empty", 32'(a_ae), 32'(aq.size() <= 2));
        chk("a_almost_full", 32'(a_af), 32'((D - aq.size()) <= 2));
        chk("p_level", 32'(p_level), 32'(pq.size()));
        chk("p_room", 32'(p_room), 32'(D - pu));
        chk("p_ready", 32'(p_ready), 32'(pu != D));
        chk("p_valid", 32'(p_mvalid), 32'(pq.size() != 0));
        chk("p_empty", 32'(p_empty), 32'(pu == 0));
        chk("p_almost_empty", 32'(p_ae), 32'(pq.size() <= 2));
        chk("p_almost_full", 32'(p_af), 32'((D - pu) <= 2));
    endtask

    // One clock of stimulus; the stream instance also sees last/abort, which it must ignore.
    task automatic cyc(input logic asv, input logic amr,
                       input logic psv, input logic psl, input logic psa, input logic pmr);
        logic a_acc, a_racc, p_acc, p_racc;
        int   e;
        a_sv = asv; a_sl = asv; a_sa = asv; a_mr = amr;
        p_sv = psv; p_sl = psl; p_sa = psa; p_mr = pmr;
        #1;
        a_acc  = a_sv && a_ready;
        a_racc = a_mvalid && a_mr;
        p_acc  = p_sv && p_ready;
        p_racc = p_mvalid && p_mr;
        if (a_racc) begin
            chk("a_sb_underflow", 32'(aq.size() == 0), 32'(0));
            if (aq.size() > 0) begin
                e = aq.pop_front();
                chk("a_raddr_next", 32'(a_raddr), 32'((e + 1) % D));
            end
        end
        if (a_acc) aq.push_back(int'(a_waddr));
        if (p_racc) begin
            chk("p_sb_underflow", 32'(pq.size() == 0), 32'(0));
            if (pq.size() > 0) begin
                e = pq.pop_front();
                chk("p_raddr_next", 32'(p_raddr), 32'((e + 1) % D));
            end
        end
        if (p_acc) pend.push_back(int'(p_waddr));
        if (p_acc && p_sl) begin
            foreach (pend[i]) pq.push_back(pend[i]);
            pend.delete();
        end else if (p_sa) begin
            pend.delete();
        end
        @(posedge clk);
        #1;
        a_sv = 0; a_sl = 0; a_sa = 0; a_mr = 0;
        p_sv = 0; p_sl = 0; p_sa = 0; p_mr = 0;
        #1;
        check_model();
    endtask

    // Reset with optional live handshakes, which must be ignored.
    task automatic do_reset(input logic busy);
        resetn = 1'b0;
        a_sv = busy; a_sl = busy; a_sa = busy; a_mr = busy;
        p_sv = busy; p_sl = busy; p_sa = 1'b0; p_mr = busy;
        @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_mvalid), 32'(0));
        chk("rst_a_ready", 32'(a_ready), 32'(1));
        chk("rst_a_empty", 32'(a_empty), 32'(1));
        chk("rst_a_level", 32'(a_level), 32'(0));
        chk("rst_a_room", 32'(a_room), 32'(D));
        chk("rst_a_ae", 32'(a_ae), 32'(1));
        chk("rst_a_af", 32'(a_af), 32'(0));
        chk("rst_a_raddr_next", 32'(a_raddr), 32'(0));
        chk("rst_a_waddr", 32'(a_waddr), 32'(0));
        chk("rst_p_valid", 32'(p_mvalid), 32'(0));
        chk("rst_p_room", 32'(p_room), 32'(D));
        chk("rst_p_raddr_next", 32'(p_raddr), 32'(0));
        a_sv = 0; a_sl = 0; a_sa = 0; a_mr = 0;
        p_sv = 0; p_sl = 0; p_sa = 0; p_mr = 0;
        resetn = 1'b1;
        aq.delete(); pq.delete(); pend.delete();
        #1;
        check_model();
    endtask

    initial begin
        resetn = 1'b0;
        a_sv = 0; a_sl = 0; a_sa = 0; a_mr = 0;
        p_sv = 0; p_sl = 0; p_sa = 0; p_mr = 0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Fill the stream instance to full.
        for (int i = 0; i < D; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("fill_ready", 32'(a_ready), 32'(0));
        chk("fill_room", 32'(a_room), 32'(0));
        chk("fill_level", 32'(a_level), 32'(16));
        cyc(1, 0, 0, 0, 0, 0);
        chk("fill_17th_waddr", 32'(a_waddr), 32'(0));

        // Full with simultaneous read and write: only the read goes.
        cyc(1, 1, 0, 0, 0, 0);
        chk("full_rw_level", 32'(a_level), 32'(15));
        chk("full_rw_ready", 32'(a_ready), 32'(1));
        chk("full_rw_raddr_next", 32'(a_raddr), 32'(1));
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("drain_empty", 32'(a_empty), 32'(1));

        // Empty with simultaneous read and write: only the write goes.
        cyc(1, 1, 0, 0, 0, 0);
        chk("empty_rw_valid", 32'(a_mvalid), 32'(1));
        chk("empty_rw_level", 32'(a_level), 32'(1));
        chk("empty_rw_empty", 32'(a_empty), 32'(0));

        // Reset with live handshakes, then wrap-around streaming.
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            chk("wrap_waddr", 32'(a_waddr), 32'(i % D));
            cyc(1, (i >= 3), 0, 0, 0, 0);
            chk("wrap_level_le4", 32'(a_level <= 4), 32'(1));
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("wrap_end_empty", 32'(a_empty), 32'(1));
        chk("wrap_end_level", 32'(a_level), 32'(0));

        // Packet of 5 beats committed by last.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("pkt_valid_pending", 32'(p_mvalid), 32'(0));
        chk("pkt_room_pending", 32'(p_room), 32'(12));
        cyc(0, 0, 1, 1, 0, 0);
        chk("pkt_valid_commit", 32'(p_mvalid), 32'(1));
        chk("pkt_level_commit", 32'(p_level), 32'(5));
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);

        // Three beats then abort with a beat presented in the abort cycle.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("abort_room", 32'(p_room), 32'(16));
        chk("abort_empty", 32'(p_empty), 32'(1));
        chk("abort_valid", 32'(p_mvalid), 32'(0));
        chk("abort_next_waddr", 32'(p_waddr), 32'(5));
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        chk("abort_last_level", 32'(p_level), 32'(2));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("pkt_final_empty", 32'(p_empty), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
